// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with a 2-entry skid buffer and branch resolution.
// Ports: clk/rst_n (async active-low); in_valid/in_ready with alu_out, zero_flag, store_data,
// dest_reg, mem_read, mem_write, reg_write, branch, branch_target; flush; out_valid/out_ready
// with out_alu, out_store_data, out_dest, out_mem_read, out_mem_write, out_reg_write;
// branch_taken/branch_pc. Optional macro EX_MEM_FWD_EN adds fwd_valid/fwd_dest/fwd_data.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              zero_flag,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              branch,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_pc
`ifdef EX_MEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dest,
    output logic [DATA_W-1:0] fwd_data
`endif
);
    localparam int EW = 2 * DATA_W + REG_W + 3;
    logic [EW-1:0] main_q, main_d, skid_q, skid_d, in_ent;
    logic main_v_q, main_v_d, skid_v_q, skid_v_d, bt_q, bt_d;
    logic [DATA_W-1:0] bpc_q, bpc_d;
    logic accept, drain, mr, mw, rw;
    assign in_ent = {alu_out, store_data, dest_reg, mem_read, mem_write, reg_write};
    assign in_ready = !skid_v_q;
    // a flushed accept is dropped entirely, including its branch pulse
    assign accept = in_valid && in_ready && !flush;
    assign drain = main_v_q && out_ready;
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (drain && skid_v_q) begin
            main_d = skid_q;
            skid_v_d = 1'b0;
        end else if (accept && (!main_v_q || drain)) begin
            main_d = in_ent;
            main_v_d = 1'b1;
        end else if (accept) begin
            skid_d = in_ent;
            skid_v_d = 1'b1;
        end else if (drain) begin
            main_v_d = 1'b0;
        end
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
        bt_d = accept && branch && zero_flag;
        bpc_d = bt_d ? branch_target : bpc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            bt_q <= 1'b0;
            bpc_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            bt_q <= bt_d;
            bpc_q <= bpc_d;
        end
    end
    assign {out_alu, out_store_data, out_dest, mr, mw, rw} = main_q;
    assign out_valid = main_v_q;
    assign out_mem_read = main_v_q && mr;
    assign out_mem_write = main_v_q && mw;
    assign out_reg_write = main_v_q && rw;
    assign branch_taken = bt_q;
    assign branch_pc = bpc_q;
`ifdef EX_MEM_FWD_EN
    assign fwd_valid = out_reg_write && !out_mem_read && (out_dest != '0);
    assign fwd_dest = out_dest;
    assign fwd_data = out_alu;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vector table, corner sequences and random model check of ex_mem_stage.
module tb_ex_mem_stage;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid, in_ready, zero_flag, mem_read, mem_write, reg_write, branch, flush;
    logic out_valid, out_ready, out_mem_read, out_mem_write, out_reg_write, branch_taken;
    logic [31:0] alu_out, store_data, branch_target, out_alu, out_store_data, branch_pc;
    logic [4:0] dest_reg, out_dest;
`ifdef EX_MEM_FWD_EN
    logic fwd_valid;
    logic [4:0] fwd_dest;
    logic [31:0] fwd_data;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .zero_flag(zero_flag), .store_data(store_data),
        .dest_reg(dest_reg), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .branch(branch), .branch_target(branch_target),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu),
        .out_store_data(out_store_data), .out_dest(out_dest), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
        .branch_taken(branch_taken), .branch_pc(branch_pc)
`ifdef EX_MEM_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`endif
    );

    typedef struct {
        logic iv, ordy, fl;
        logic [31:0] alu;
        logic [4:0] dst;
        logic rw, br, z;
        logic [31:0] tgt;
        logic ov, ir;
        logic [31:0] oalu;
        logic [4:0] odst;
        logic orw, bt;
        logic [31:0] bpc;
    } vec_t;

    typedef struct {
        logic [31:0] alu, sd;
        logic [4:0] dst;
        logic mr, mw, rw;
    } ent_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = 0; out_ready = 0; flush = 0; alu_out = 0; zero_flag = 0; store_data = 0;
        dest_reg = 0; mem_read = 0; mem_write = 0; reg_write = 0; branch = 0; branch_target = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[18];
    ent_t q[$];
    ent_t e;
    logic [31:0] m_bpc;
    logic m_bt, acc, drn;

    initial begin
        tbl[0]  = '{1,1,0,7,5,1,0,0,0,             1,1,7,5,1,0,0};
        tbl[1]  = '{0,1,0,0,0,0,0,0,0,             0,1,0,0,0,0,0};
        tbl[2]  = '{1,0,0,10,1,1,0,0,0,            1,1,10,1,1,0,0};
        tbl[3]  = '{1,0,0,11,2,1,0,0,0,            1,0,10,1,1,0,0};
        tbl[4]  = '{1,0,0,12,3,1,0,0,0,            1,0,10,1,1,0,0};
        tbl[5]  = '{1,1,0,12,3,1,0,0,0,            1,1,11,2,1,0,0};
        tbl[6]  = '{1,1,0,12,3,1,0,0,0,            1,1,12,3,1,0,0};
        tbl[7]  = '{0,1,0,0,0,0,0,0,0,             0,1,0,0,0,0,0};
        tbl[8]  = '{1,1,0,0,0,0,1,1,32'h00400020,  1,1,0,0,0,1,32'h00400020};
        tbl[9]  = '{0,1,0,0,0,0,0,0,0,             0,1,0,0,0,0,32'h00400020};
        tbl[10] = '{1,1,0,0,0,0,1,0,32'h1234,      1,1,0,0,0,0,32'h00400020};
        tbl[11] = '{0,1,0,0,0,0,0,0,0,             0,1,0,0,0,0,32'h00400020};
        tbl[12] = '{1,0,0,20,4,1,0,0,0,            1,1,20,4,1,0,32'h00400020};
        tbl[13] = '{1,0,0,21,6,1,0,0,0,            1,0,20,4,1,0,32'h00400020};
        tbl[14] = '{1,0,1,0,0,0,1,1,32'h99,        0,1,0,0,0,0,32'h00400020};
        tbl[15] = '{1,0,0,30,7,1,0,0,0,            1,1,30,7,1,0,32'h00400020};
        tbl[16] = '{1,0,1,0,0,0,1,1,32'h99,        0,1,0,0,0,0,32'h00400020};
        tbl[17] = '{0,1,0,0,0,0,0,0,0,             0,1,0,0,0,0,32'h00400020};

        idle();
        in_valid = 1;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_alu", out_alu, 0);
        chk("rst_branch_taken", branch_taken, 0);
        chk("rst_branch_pc", branch_pc, 0);
        idle();
        rst_n = 1;
        step();

        for (int i = 0; i < 18; i++) begin
            idle();
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            alu_out = tbl[i].alu; dest_reg = tbl[i].dst; reg_write = tbl[i].rw;
            branch = tbl[i].br; zero_flag = tbl[i].z; branch_target = tbl[i].tgt;
            step();
            chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("v%0d_reg_write", i), out_reg_write, tbl[i].orw);
            chk($sformatf("v%0d_branch_taken", i), branch_taken, tbl[i].bt);
            chk($sformatf("v%0d_branch_pc", i), branch_pc, tbl[i].bpc);
            if (tbl[i].ov) begin
                chk($sformatf("v%0d_out_alu", i), out_alu, tbl[i].oalu);
                chk($sformatf("v%0d_out_dest", i), out_dest, tbl[i].odst);
            end
        end

        for (int i = 1; i <= 8; i++) begin
            idle();
            in_valid = 1; out_ready = 1; alu_out = i;
            step();
            chk($sformatf("stream%0d_alu", i), out_alu, i);
            chk($sformatf("stream%0d_valid", i), out_valid, 1);
            chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
        end
        idle();
        out_ready = 1;
        step();
        chk("stream_end_valid", out_valid, 0);

`ifdef EX_MEM_FWD_EN
        idle();
        in_valid = 1; reg_write = 1; dest_reg = 3; alu_out = 32'h55;
        step();
        chk("fwd_valid", fwd_valid, 1);
        chk("fwd_dest", fwd_dest, 3);
        chk("fwd_data", fwd_data, 32'h55);
        idle();
        in_valid = 1; out_ready = 1; reg_write = 1; dest_reg = 0; alu_out = 32'h66;
        step();
        chk("fwd_valid_r0", fwd_valid, 0);
        idle();
        in_valid = 1; out_ready = 1; reg_write = 1; mem_read = 1; dest_reg = 4;
        step();
        chk("fwd_valid_load", fwd_valid, 0);
        idle();
        out_ready = 1;
        step();
`endif

        idle();
        in_valid = 1; alu_out = 32'hA1;
        step();
        alu_out = 32'hA2;
        step();
        chk("mid_stall_full", in_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_alu", out_alu, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_bpc", branch_pc, 0);
        step();
        idle();
        #2 rst_n = 1;
        out_ready = 1;
        step();
        chk("post_rst_valid", out_valid, 0);
        step();
        chk("post_rst_valid2", out_valid, 0);

        m_bpc = 0;
        m_bt = 0;
        for (int c = 0; c < 2000; c++) begin
            chk("rnd_in_ready", in_ready, q.size() < 2);
            chk("rnd_out_valid", out_valid, q.size() > 0);
            chk("rnd_branch_taken", branch_taken, m_bt);
            chk("rnd_branch_pc", branch_pc, m_bpc);
            if (q.size() > 0) begin
                chk("rnd_out_alu", out_alu, q[0].alu);
                chk("rnd_out_sd", out_store_data, q[0].sd);
                chk("rnd_out_dest", out_dest, q[0].dst);
                chk("rnd_ctrl", {out_mem_read, out_mem_write, out_reg_write},
                    {q[0].mr, q[0].mw, q[0].rw});
            end else begin
                chk("rnd_ctrl_idle", {out_mem_read, out_mem_write, out_reg_write}, 0);
            end
`ifdef EX_MEM_FWD_EN
            chk("rnd_fwd_valid", fwd_valid,
                q.size() > 0 && q[0].rw && !q[0].mr && q[0].dst != 0);
`endif
            in_valid = ($urandom_range(3) != 0);
            out_ready = $urandom_range(1);
            flush = ($urandom_range(15) == 0);
            alu_out = $urandom; store_data = $urandom; dest_reg = 5'($urandom);
            mem_read = $urandom_range(1); mem_write = $urandom_range(1);
            reg_write = $urandom_range(1); branch = $urandom_range(1);
            zero_flag = $urandom_range(1); branch_target = $urandom;
            acc = in_valid && q.size() < 2 && !flush;
            drn = q.size() > 0 && out_ready;
            m_bt = acc && branch && zero_flag;
            if (m_bt) m_bpc = branch_target;
            if (drn) void'(q.pop_front());
            if (flush) q.delete();
            if (acc) begin
                e = '{alu_out, store_data, dest_reg, mem_read, mem_write, reg_write};
                q.push_back(e);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
